// File: rtl/intraloop_sequencer.sv
// Frame-level intra-loop sequencer: walks every luma 4x4 / chroma 8x8 block, launches a one-hot
// stage token per block and waits for reconstructor write-back before launching the next one.
module intraloop_sequencer #(
    parameter int N_STAGES      = 12,
    parameter int MB_W          = 32,
    parameter int LUMA_BLOCKS   = 57600,
    parameter int CHROMA_BLOCKS = 14400,
    parameter int FB_TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                fb_luma4x4,
    input  logic                fb_chromab8x8,
    input  logic                fb_chromar8x8,
    output logic [N_STAGES-1:0] enabler,
    output logic [MB_W-1:0]     mbnumber_luma4x4,
    output logic [MB_W-1:0]     mbnumber_chromab8x8,
    output logic [MB_W-1:0]     mbnumber_chromar8x8,
    output logic                chroma_active,
    output logic                busy,
    output logic                done,
    output logic                err_timeout
);

    if (CHROMA_BLOCKS > LUMA_BLOCKS) begin : g_bad_chroma
        $error("CHROMA_BLOCKS must not exceed LUMA_BLOCKS");
    end
    if (FB_TIMEOUT < 1) begin : g_bad_timeout
        $error("FB_TIMEOUT must be at least 1");
    end

    localparam int TW = $clog2(FB_TIMEOUT + 1);
    localparam logic [MB_W-1:0]     LUMA_LIM   = MB_W'(LUMA_BLOCKS);
    localparam logic [MB_W-1:0]     CHROMA_LIM = MB_W'(CHROMA_BLOCKS);
    localparam logic [TW-1:0]       TMO_LIM    = TW'(FB_TIMEOUT);
    localparam logic [N_STAGES-1:0] TOKEN0     = N_STAGES'(1);
    localparam logic                HAS_CHROMA = (CHROMA_BLOCKS > 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_FB
    } state_t;

    state_t              state_q, state_d;
    logic [N_STAGES-1:0] enabler_q, enabler_d;
    logic [MB_W-1:0]     luma_q, luma_d;
    logic [MB_W-1:0]     chroma_q, chroma_d;
    logic                cact_q, cact_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                flagL_q, flagL_d;
    logic                flagB_q, flagB_d;
    logic                flagR_q, flagR_d;
    logic [TW-1:0]       tmo_q, tmo_d;

    logic            haveL, haveB, haveR, blockDone;
    logic [MB_W-1:0] lumaNext, chromaNext;

    // A required feedback counts if it was captured earlier or arrives this very cycle.
    assign haveL     = flagL_q | fb_luma4x4;
    assign haveB     = flagB_q | fb_chromab8x8;
    assign haveR     = flagR_q | fb_chromar8x8;
    assign blockDone = haveL & (~cact_q | (haveB & haveR));

    always_comb begin
        state_d    = state_q;
        enabler_d  = enabler_q;
        luma_d     = luma_q;
        chroma_d   = chroma_q;
        cact_d     = cact_q;
        done_d     = 1'b0;
        err_d      = err_q;
        flagL_d    = flagL_q;
        flagB_d    = flagB_q;
        flagR_d    = flagR_q;
        tmo_d      = tmo_q;
        lumaNext   = luma_q + MB_W'(1);
        chromaNext = cact_q ? chroma_q + MB_W'(1) : chroma_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    enabler_d = TOKEN0;
                    luma_d    = '0;
                    chroma_d  = '0;
                    cact_d    = HAS_CHROMA;
                    err_d     = 1'b0;
                    flagL_d   = 1'b0;
                    flagB_d   = 1'b0;
                    flagR_d   = 1'b0;
                    tmo_d     = '0;
                end
            end
            RUN: begin
                flagL_d = haveL;
                flagB_d = haveB;
                flagR_d = haveR;
                if (!stall) begin
                    if (enabler_q[N_STAGES-1]) begin
                        enabler_d = '0;
                        state_d   = WAIT_FB;
                    end else begin
                        enabler_d = enabler_q << 1;
                    end
                end
            end
            WAIT_FB: begin
                if (blockDone) begin
                    luma_d   = lumaNext;
                    chroma_d = chromaNext;
                    cact_d   = (chromaNext < CHROMA_LIM);
                    flagL_d  = 1'b0;
                    flagB_d  = 1'b0;
                    flagR_d  = 1'b0;
                    tmo_d    = '0;
                    if (lumaNext < LUMA_LIM) begin
                        state_d   = RUN;
                        enabler_d = TOKEN0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    flagL_d = haveL;
                    flagB_d = haveB;
                    flagR_d = haveR;
                    tmo_d   = tmo_q + TW'(1);
                    if (tmo_q + TW'(1) == TMO_LIM) begin
                        // Abandon the frame; indices stay on the block that never completed.
                        state_d = IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            enabler_q <= '0;
            luma_q    <= '0;
            chroma_q  <= '0;
            cact_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flagL_q   <= 1'b0;
            flagB_q   <= 1'b0;
            flagR_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            enabler_q <= enabler_d;
            luma_q    <= luma_d;
            chroma_q  <= chroma_d;
            cact_q    <= cact_d;
            done_q    <= done_d;
            err_q     <= err_d;
            flagL_q   <= flagL_d;
            flagB_q   <= flagB_d;
            flagR_q   <= flagR_d;
            tmo_q     <= tmo_d;
        end
    end

    assign enabler             = enabler_q;
    assign mbnumber_luma4x4    = luma_q;
    assign mbnumber_chromab8x8 = chroma_q;
    assign mbnumber_chromar8x8 = chroma_q;
    assign chroma_active       = cact_q;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign err_timeout         = err_q;

endmodule
